// File: rtl/tx_pkg.sv
// Shared types and default widths for the transmit-side head reader.
package tx_pkg;

   localparam int TX_WORD_W    = 32;
   localparam int TX_SIDE_BITS = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      CAPTURE,
      HOLD
   } tx_state_t;

endpackage

// File: rtl/tx_head_reader_if.sv
// FIFO-read and transmitter handshake bundle for tx_head_reader.
// The out_parity wire exists only when TX_PARITY_EN is defined.
interface tx_head_reader_if
   import tx_pkg::*;
#(
   parameter int WORD_W    = TX_WORD_W,
   parameter int SIDE_BITS = TX_SIDE_BITS
);

   logic                 fifo_empty;
   logic                 fifo_rd;
   logic [WORD_W-1:0]    fifo_rdata;
   logic [SIDE_BITS-1:0] head_side;
   logic [WORD_W-1:0]    out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 block_done;
`ifdef TX_PARITY_EN
   logic                 out_parity;
`endif

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      input  out_ready,
      output fifo_rd,
      output head_side,
      output out_data,
      output out_valid,
`ifdef TX_PARITY_EN
      output out_parity,
`endif
      output block_done
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      output out_ready,
      input  fifo_rd,
      input  head_side,
      input  out_data,
      input  out_valid,
`ifdef TX_PARITY_EN
      input  out_parity,
`endif
      input  block_done
   );

endinterface

// File: rtl/tx_head_counter.sv
// Wrapping head-side index; wrap flags the step from the last side back to 0.
module tx_head_counter #(
   parameter int SIDE_BITS = 2
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 count_enable,
   output logic [SIDE_BITS-1:0] count,
   output logic                 wrap
);

   logic [SIDE_BITS-1:0] count_q;
   logic [SIDE_BITS-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign wrap  = count_enable && !clear && (count_q == {SIDE_BITS{1'b1}});

endmodule

// File: rtl/tx_head_reader.sv
// Reads one word per side from the word FIFO and hands it to the transmitter.
// Optional even-parity output is enabled by defining TX_PARITY_EN.
module tx_head_reader
   import tx_pkg::*;
#(
   parameter int WORD_W    = TX_WORD_W,
   parameter int SIDE_BITS = TX_SIDE_BITS
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              sync_clr,
   tx_head_reader_if.master  bus
);

   tx_state_t            state_q, state_d;
   logic [WORD_W-1:0]    out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 block_done_q, block_done_d;
   logic                 handshake;
   logic                 head_wrap;
   logic [SIDE_BITS-1:0] head_side;
`ifdef TX_PARITY_EN
   logic                 out_parity_q, out_parity_d;
`endif

   // A transfer only counts in HOLD and is cancelled by a simultaneous clear.
   assign handshake = (state_q == HOLD) && out_valid_q && bus.out_ready && !sync_clr;

   tx_head_counter #(
      .SIDE_BITS(SIDE_BITS)
   ) u_head_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (sync_clr),
      .count_enable (handshake),
      .count        (head_side),
      .wrap         (head_wrap)
   );

   always_comb begin
      state_d      = state_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      block_done_d = 1'b0;
`ifdef TX_PARITY_EN
      out_parity_d = out_parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (!bus.fifo_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            out_data_d  = bus.fifo_rdata;
            out_valid_d = 1'b1;
`ifdef TX_PARITY_EN
            out_parity_d = ^bus.fifo_rdata;
`endif
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d  = 1'b0;
               block_done_d = head_wrap;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Clear wins over everything, including a word being captured this cycle.
      if (sync_clr) begin
         state_d      = IDLE;
         out_data_d   = out_data_q;
         out_valid_d  = 1'b0;
         block_done_d = 1'b0;
`ifdef TX_PARITY_EN
         out_parity_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         block_done_q <= 1'b0;
`ifdef TX_PARITY_EN
         out_parity_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         block_done_q <= block_done_d;
`ifdef TX_PARITY_EN
         out_parity_q <= out_parity_d;
`endif
      end
   end

   assign bus.fifo_rd    = (state_q == FETCH);
   assign bus.head_side  = head_side;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.block_done = block_done_q;
`ifdef TX_PARITY_EN
   assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_tx_head_reader.sv
// Scoreboard bench for tx_head_reader: directed scenarios plus random traffic
// against a word-queue model of the FIFO and the expected side sequence.
module tb_tx_head_reader;
   import tx_pkg::*;

   localparam int SIDES = 1 << TX_SIDE_BITS;

   logic clk = 1'b0;
   logic n_rst;
   logic sync_clr;

   tx_head_reader_if bus ();

   tx_head_reader dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .sync_clr (sync_clr),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] fifoWords[$];
   logic [31:0] expQ[$];
   int          expSide  = 0;
   logic        doneNext = 1'b0;
   logic        prevRd   = 1'b0;
   logic        lastRd   = 1'b0;
   logic [31:0] respWord;
   logic [31:0] monWord;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s (bound expired or impossible event)", name);
   endtask

   // FIFO model: hands out the next queued word when the DUT strobes a read
   // and keeps it stable through the capture cycle; otherwise drives noise.
   always @(posedge clk) begin
      #1;
      if (!n_rst) begin
         prevRd = 1'b0;
      end else if (bus.fifo_rd) begin
         if (fifoWords.size() == 0) begin
            failNow("fetch_from_empty");
         end else begin
            respWord = fifoWords.pop_front();
            bus.fifo_rdata = respWord;
            expQ.push_back(respWord);
         end
         prevRd = 1'b1;
      end else begin
         if (!prevRd) bus.fifo_rdata = $urandom;
         prevRd = 1'b0;
      end
      bus.fifo_empty = (fifoWords.size() == 0);
   end

   // Monitor: compares every accepted word and the block_done pulse.
   always @(negedge clk) begin
      if (!n_rst) begin
         expQ.delete();
         expSide  = 0;
         doneNext = 1'b0;
         lastRd   = 1'b0;
      end else begin
         checkOutput("block_done", 32'(bus.block_done), 32'(doneNext));
         if (bus.fifo_rd) begin
            checkOutput("no_read_while_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("read_single_cycle", 32'(lastRd), 32'd0);
         end
         lastRd = bus.fifo_rd;
         if (sync_clr) begin
            expQ.delete();
            expSide  = 0;
            doneNext = 1'b0;
         end else if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               failNow("unexpected_transfer");
            end else begin
               monWord = expQ.pop_front();
               checkOutput("xfer_data", bus.out_data, monWord);
`ifdef TX_PARITY_EN
               checkOutput("xfer_parity", 32'(bus.out_parity), 32'(^monWord));
`endif
            end
            checkOutput("xfer_side", 32'(bus.head_side), 32'(expSide));
            doneNext = (expSide == SIDES - 1);
            expSide  = (expSide + 1) % SIDES;
         end else begin
            doneNext = 1'b0;
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic pushWord(input logic [31:0] w);
      fifoWords.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic waitValid(input string name);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) failNow(name);
   endtask

   task automatic drain(input string name);
      int n = 0;
      nextCycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      while ((fifoWords.size() != 0 || expQ.size() != 0 || bus.out_valid || bus.fifo_rd) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) failNow(name);
      checkOutput({name, "_scoreboard_empty"}, 32'(expQ.size()), 32'd0);
   endtask

   task automatic applyStimulus();
      logic [31:0] held;
      int n;

      // Single word: read strobe in cycle 1, word presented in cycle 3.
      nextCycle();
      bus.out_ready = 1'b1;
      pushWord(32'h12345678);
      @(negedge clk);
      checkOutput("single_c0_rd", 32'(bus.fifo_rd), 32'd0);
      @(negedge clk);
      checkOutput("single_c1_rd", 32'(bus.fifo_rd), 32'd1);
      checkOutput("single_c1_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      checkOutput("single_c2_rd", 32'(bus.fifo_rd), 32'd0);
      checkOutput("single_c2_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      checkOutput("single_c3_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("single_c3_data", bus.out_data, 32'h12345678);
      checkOutput("single_c3_side", 32'(bus.head_side), 32'd0);
      @(negedge clk);
      checkOutput("single_c4_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("single_c4_side", 32'(bus.head_side), 32'd1);

      // Backpressure: word stays put and no further reads while held.
      nextCycle();
      bus.out_ready = 1'b0;
      pushWord(32'hB0B0_0001);
      pushWord(32'hB0B0_0002);
      waitValid("bp_wait_valid");
      held = bus.out_data;
      checkOutput("bp_first_word", held, 32'hB0B0_0001);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_valid_stable", 32'(bus.out_valid), 32'd1);
         checkOutput("bp_data_stable", bus.out_data, held);
         checkOutput("bp_no_read", 32'(bus.fifo_rd), 32'd0);
      end
      nextCycle();
      bus.out_ready = 1'b1;
      nextCycle();
      bus.out_ready = 1'b0;
      @(negedge clk);
      checkOutput("bp_one_transfer", 32'(bus.out_valid), 32'd0);
      waitValid("bp_wait_second");
      checkOutput("bp_second_word", bus.out_data, 32'hB0B0_0002);
      checkOutput("bp_second_side", 32'(bus.head_side), 32'd2);
      nextCycle();
      bus.out_ready = 1'b1;
      nextCycle();
      bus.out_ready = 1'b0;

      // Asynchronous reset in the middle of HOLD.
      pushWord(32'hDEADBEEF);
      waitValid("rst_wait_valid");
      checkOutput("rst_pre_data", bus.out_data, 32'hDEADBEEF);
      @(posedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_data", bus.out_data, 32'd0);
      checkOutput("rst_side", 32'(bus.head_side), 32'd0);
      checkOutput("rst_rd", 32'(bus.fifo_rd), 32'd0);
      checkOutput("rst_done", 32'(bus.block_done), 32'd0);
`ifdef TX_PARITY_EN
      checkOutput("rst_parity", 32'(bus.out_parity), 32'd0);
`endif
      nextCycle();
      n_rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_rd", 32'(bus.fifo_rd), 32'd0);
      checkOutput("rst_release_valid", 32'(bus.out_valid), 32'd0);

      // Full block and wrap, then a fifth word on side 0.
      nextCycle();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) pushWord(32'hA0 + 32'(i));
      n = 0;
      @(negedge clk);
      while (!bus.block_done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!bus.block_done) failNow("block_done_timeout");
      checkOutput("block_wrap_side", 32'(bus.head_side), 32'd0);
      drain("block_drain");
      checkOutput("block_fifth_side", 32'(bus.head_side), 32'd1);

      // Clear while capturing on side 2.
      nextCycle();
      pushWord(32'hC0C0_0001);
      drain("clr_prep");
      nextCycle();
      pushWord(32'hC0C0_0002);
      n = 0;
      @(negedge clk);
      while (!bus.fifo_rd && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.fifo_rd) failNow("clr_wait_read");
      nextCycle();
      checkOutput("clr_capture_side", 32'(bus.head_side), 32'd2);
      sync_clr = 1'b1;
      nextCycle();
      sync_clr = 1'b0;
      checkOutput("clr_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("clr_side", 32'(bus.head_side), 32'd0);
      checkOutput("clr_done", 32'(bus.block_done), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("clr_word_dropped", 32'(bus.out_valid), 32'd0);
      end

`ifdef TX_PARITY_EN
      nextCycle();
      bus.out_ready = 1'b0;
      pushWord(32'h0000_0007);
      waitValid("par_wait_a");
      checkOutput("parity_7", 32'(bus.out_parity), 32'd1);
      nextCycle();
      bus.out_ready = 1'b1;
      nextCycle();
      bus.out_ready = 1'b0;
      pushWord(32'h0000_0003);
      waitValid("par_wait_b");
      checkOutput("parity_3", 32'(bus.out_parity), 32'd0);
      drain("par_drain");
`endif

      // Random traffic with occasional clears.
      for (int i = 0; i < 500; i++) begin
         nextCycle();
         if ($urandom_range(0, 2) == 0) pushWord($urandom);
         bus.out_ready = ($urandom_range(0, 1) == 1);
         sync_clr      = ($urandom_range(0, 39) == 0);
      end
      nextCycle();
      sync_clr = 1'b0;
      drain("random_drain");
   endtask

   initial begin
      n_rst          = 1'b0;
      sync_clr       = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_rdata = '0;
      bus.out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_side", 32'(bus.head_side), 32'd0);
      checkOutput("reset_data", bus.out_data, 32'd0);
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
